// File: rtl/gwa_vend_ctrl.sv
// gwa_vend_ctrl: two-coin vending controller with a binary credit counter.
// Takes 1/2-euro coins, vends product A or B at parameterised prices and
// pays change back one coin at a time through a handshaked hopper.
// Optional feature macro: GWA_SALES_CNT_EN adds a 16-bit wrapping sales counter.
module gwa_vend_ctrl #(
  parameter int MAX_CREDIT = 6,
  parameter int PRICE_A    = 2,
  parameter int PRICE_B    = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            eu1,
  input  logic                            eu2,
  input  logic                            sel_a,
  input  logic                            sel_b,
  input  logic                            cancel,
  input  logic                            chg_rdy,
  output logic                            vend_a,
  output logic                            vend_b,
  output logic                            eu1o,
  output logic                            eu2o,
  output logic                            coin_rej,
  output logic                            no_fund,
  output logic [$clog2(MAX_CREDIT+1)-1:0] credit,
  output logic                            busy
`ifdef GWA_SALES_CNT_EN
  ,
  output logic [15:0]                     sales_cnt
`endif
);

  localparam int CW = $clog2(MAX_CREDIT + 1);

  // One extra bit so credit + coin never wraps before the limit compare.
  localparam logic [CW:0] MAX_W = (CW + 1)'(MAX_CREDIT);
  localparam logic [CW:0] PA_W  = (CW + 1)'(PRICE_A);
  localparam logic [CW:0] PB_W  = (CW + 1)'(PRICE_B);
  localparam logic [CW:0] ONE_W = (CW + 1)'(1);
  localparam logic [CW:0] TWO_W = (CW + 1)'(2);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          vend_a_q, vend_a_d;
  logic          vend_b_q, vend_b_d;
  logic          eu1o_q, eu1o_d;
  logic          eu2o_q, eu2o_d;
  logic          coin_rej_q, coin_rej_d;
  logic          no_fund_q, no_fund_d;
  logic          busy_q, busy_d;
  logic [CW:0]   credit_w;
  logic [CW:0]   credit_d_w;

  assign credit_w   = {1'b0, credit_q};
  assign credit_d_w = {1'b0, credit_d};

  // Next-state, credit arithmetic and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    vend_a_d   = 1'b0;
    vend_b_d   = 1'b0;
    coin_rej_d = 1'b0;
    no_fund_d  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (cancel) begin
          if (credit_q != '0) state_d = CHANGE;
          coin_rej_d = eu1 | eu2;
        end else if (sel_a) begin
          if (credit_w >= PA_W) begin
            credit_d = CW'(credit_w - PA_W);
            vend_a_d = 1'b1;
            state_d  = VEND;
          end else begin
            no_fund_d = 1'b1;
          end
          coin_rej_d = eu1 | eu2;
        end else if (sel_b) begin
          if (credit_w >= PB_W) begin
            credit_d = CW'(credit_w - PB_W);
            vend_b_d = 1'b1;
            state_d  = VEND;
          end else begin
            no_fund_d = 1'b1;
          end
          coin_rej_d = eu1 | eu2;
        end else if (eu1) begin
          // A simultaneous 2-euro coin is always bounced; only eu1 is counted.
          if (credit_w + ONE_W <= MAX_W) credit_d = CW'(credit_w + ONE_W);
          else                           coin_rej_d = 1'b1;
          if (eu2) coin_rej_d = 1'b1;
        end else if (eu2) begin
          if (credit_w + TWO_W <= MAX_W) credit_d = CW'(credit_w + TWO_W);
          else                           coin_rej_d = 1'b1;
        end
      end
      VEND: begin
        coin_rej_d = eu1 | eu2;
        state_d    = (credit_q != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        coin_rej_d = eu1 | eu2;
        // The coin leaves only when the hopper takes the request shown now.
        if (chg_rdy && eu2o_q)      credit_d = CW'(credit_w - TWO_W);
        else if (chg_rdy && eu1o_q) credit_d = CW'(credit_w - ONE_W);
        if (credit_d == '0) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    // Eject request follows the credit left after this cycle's transfer.
    eu2o_d = (state_d == CHANGE) && (credit_d_w >= TWO_W);
    eu1o_d = (state_d == CHANGE) && (credit_d_w == ONE_W);
    busy_d = (state_d != COLLECT);
  end

  // State, credit and output registers; reset discards any held credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= COLLECT;
      credit_q   <= '0;
      vend_a_q   <= 1'b0;
      vend_b_q   <= 1'b0;
      eu1o_q     <= 1'b0;
      eu2o_q     <= 1'b0;
      coin_rej_q <= 1'b0;
      no_fund_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      vend_a_q   <= vend_a_d;
      vend_b_q   <= vend_b_d;
      eu1o_q     <= eu1o_d;
      eu2o_q     <= eu2o_d;
      coin_rej_q <= coin_rej_d;
      no_fund_q  <= no_fund_d;
      busy_q     <= busy_d;
    end
  end

  assign vend_a   = vend_a_q;
  assign vend_b   = vend_b_q;
  assign eu1o     = eu1o_q;
  assign eu2o     = eu2o_q;
  assign coin_rej = coin_rej_q;
  assign no_fund  = no_fund_q;
  assign credit   = credit_q;
  assign busy     = busy_q;

`ifdef GWA_SALES_CNT_EN
  logic [15:0] sales_cnt_q, sales_cnt_d;

  assign sales_cnt_d = sales_cnt_q + 16'd1;

  // Counts in step with the vend pulse it accompanies; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)                       sales_cnt_q <= 16'd0;
    else if (vend_a_d || vend_b_d) sales_cnt_q <= sales_cnt_d;
  end

  assign sales_cnt = sales_cnt_q;
`endif

endmodule

// File: tb/tb_gwa_vend_ctrl.sv
// Directed testbench for gwa_vend_ctrl at default parameters.
module tb_gwa_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       eu1 = 1'b0, eu2 = 1'b0, sel_a = 1'b0, sel_b = 1'b0, cancel = 1'b0;
  logic       chg_rdy = 1'b0;
  logic       vend_a, vend_b, eu1o, eu2o, coin_rej, no_fund, busy;
  logic [2:0] credit;
`ifdef GWA_SALES_CNT_EN
  logic [15:0] sales_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  gwa_vend_ctrl dut (
    .clk(clk), .rst(rst), .eu1(eu1), .eu2(eu2), .sel_a(sel_a), .sel_b(sel_b),
    .cancel(cancel), .chg_rdy(chg_rdy), .vend_a(vend_a), .vend_b(vend_b),
    .eu1o(eu1o), .eu2o(eu2o), .coin_rej(coin_rej), .no_fund(no_fund),
    .credit(credit), .busy(busy)
`ifdef GWA_SALES_CNT_EN
    , .sales_cnt(sales_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then drop all pulse inputs; outputs read after this
  // reflect the edge just taken.
  task automatic tick();
    @(posedge clk);
    #1;
    eu1 = 1'b0; eu2 = 1'b0; sel_a = 1'b0; sel_b = 1'b0; cancel = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    total_cnt++; if (credit !== 3'd0) $display("FAIL reset_credit got %0d exp 0", credit); else pass_cnt++;
    total_cnt++; if ({vend_a, vend_b, eu1o, eu2o, coin_rej, no_fund, busy} !== 7'b0)
      $display("FAIL reset_outputs got %b exp 0000000", {vend_a, vend_b, eu1o, eu2o, coin_rej, no_fund, busy});
    else pass_cnt++;
    $display("reset: credit=%0d busy=%0d", credit, busy);
  endtask

  task automatic test_vend_b();
    eu2 = 1'b1; tick();
    total_cnt++; if (credit !== 3'd2) $display("FAIL vb_credit2 got %0d exp 2", credit); else pass_cnt++;
    eu1 = 1'b1; tick();
    total_cnt++; if (credit !== 3'd3) $display("FAIL vb_credit3 got %0d exp 3", credit); else pass_cnt++;
    sel_b = 1'b1; tick();
    total_cnt++; if ({vend_b, vend_a, busy, credit} !== {3'b101, 3'd0})
      $display("FAIL vb_vend got vend_b=%b vend_a=%b busy=%b credit=%0d exp 1 0 1 0", vend_b, vend_a, busy, credit);
    else pass_cnt++;
    tick();
    total_cnt++; if ({vend_b, busy, eu1o, eu2o} !== 4'b0000)
      $display("FAIL vb_back got vend_b=%b busy=%b eu1o=%b eu2o=%b exp 0000", vend_b, busy, eu1o, eu2o);
    else pass_cnt++;
    $display("vend_b: credit=%0d busy=%0d", credit, busy);
  endtask

  task automatic test_overflow_change();
    chg_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin eu2 = 1'b1; tick(); end
    total_cnt++; if (credit !== 3'd6) $display("FAIL ov_credit6 got %0d exp 6", credit); else pass_cnt++;
    eu1 = 1'b1; tick();
    total_cnt++; if ({coin_rej, credit} !== {1'b1, 3'd6})
      $display("FAIL ov_reject got coin_rej=%b credit=%0d exp 1 6", coin_rej, credit);
    else pass_cnt++;
    sel_a = 1'b1; tick();
    total_cnt++; if ({vend_a, credit} !== {1'b1, 3'd4})
      $display("FAIL ov_vend_a got vend_a=%b credit=%0d exp 1 4", vend_a, credit);
    else pass_cnt++;
    tick();
    total_cnt++; if ({eu2o, eu1o, credit} !== {2'b10, 3'd4})
      $display("FAIL ov_eject1 got eu2o=%b eu1o=%b credit=%0d exp 1 0 4", eu2o, eu1o, credit);
    else pass_cnt++;
    tick();
    total_cnt++; if ({eu2o, eu1o, credit} !== {2'b10, 3'd2})
      $display("FAIL ov_eject2 got eu2o=%b eu1o=%b credit=%0d exp 1 0 2", eu2o, eu1o, credit);
    else pass_cnt++;
    tick();
    total_cnt++; if ({eu2o, eu1o, busy, credit} !== {3'b000, 3'd0})
      $display("FAIL ov_done got eu2o=%b eu1o=%b busy=%b credit=%0d exp 0 0 0 0", eu2o, eu1o, busy, credit);
    else pass_cnt++;
    chg_rdy = 1'b0;
    $display("overflow/change: credit=%0d busy=%0d", credit, busy);
  endtask

  task automatic test_no_fund_cancel();
    chg_rdy = 1'b0;
    eu1 = 1'b1; tick();
    sel_b = 1'b1; tick();
    total_cnt++; if ({no_fund, vend_b, credit} !== {2'b10, 3'd1})
      $display("FAIL nf_flag got no_fund=%b vend_b=%b credit=%0d exp 1 0 1", no_fund, vend_b, credit);
    else pass_cnt++;
    cancel = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if ({eu1o, eu2o, busy, credit} !== {3'b101, 3'd1})
        $display("FAIL nf_hold%0d got eu1o=%b eu2o=%b busy=%b credit=%0d exp 1 0 1 1", i, eu1o, eu2o, busy, credit);
      else pass_cnt++;
      tick();
    end
    chg_rdy = 1'b1; tick();
    total_cnt++; if ({eu1o, busy, credit} !== {2'b00, 3'd0})
      $display("FAIL nf_paid got eu1o=%b busy=%b credit=%0d exp 0 0 0", eu1o, busy, credit);
    else pass_cnt++;
    chg_rdy = 1'b0;
    $display("no_fund/cancel: credit=%0d busy=%0d", credit, busy);
  endtask

  task automatic test_both_sel();
    chg_rdy = 1'b1;
    eu2 = 1'b1; tick();
    eu1 = 1'b1; tick();
    sel_a = 1'b1; sel_b = 1'b1; tick();
    total_cnt++; if ({vend_a, vend_b, credit} !== {2'b10, 3'd1})
      $display("FAIL bs_vend got vend_a=%b vend_b=%b credit=%0d exp 1 0 1", vend_a, vend_b, credit);
    else pass_cnt++;
    tick();
    total_cnt++; if ({eu1o, eu2o} !== 2'b10) $display("FAIL bs_eject got eu1o=%b eu2o=%b exp 1 0", eu1o, eu2o); else pass_cnt++;
    tick();
    total_cnt++; if ({eu1o, busy, credit} !== {2'b00, 3'd0})
      $display("FAIL bs_done got eu1o=%b busy=%b credit=%0d exp 0 0 0", eu1o, busy, credit);
    else pass_cnt++;
    eu1 = 1'b1; eu2 = 1'b1; tick();
    total_cnt++; if ({coin_rej, credit} !== {1'b1, 3'd1})
      $display("FAIL bs_dual_coin got coin_rej=%b credit=%0d exp 1 1", coin_rej, credit);
    else pass_cnt++;
    cancel = 1'b1; tick();
    eu2 = 1'b1; tick();
    total_cnt++; if ({coin_rej, busy, credit} !== {2'b10, 3'd0})
      $display("FAIL bs_change_rej got coin_rej=%b busy=%b credit=%0d exp 1 0 0", coin_rej, busy, credit);
    else pass_cnt++;
    chg_rdy = 1'b0;
    $display("both_sel: credit=%0d busy=%0d", credit, busy);
  endtask

  task automatic test_sel_with_coin();
    sel_a = 1'b1; eu1 = 1'b1; tick();
    total_cnt++; if ({no_fund, coin_rej, vend_a, credit} !== {3'b110, 3'd0})
      $display("FAIL sc_flags got no_fund=%b coin_rej=%b vend_a=%b credit=%0d exp 1 1 0 0", no_fund, coin_rej, vend_a, credit);
    else pass_cnt++;
    $display("sel_with_coin: credit=%0d", credit);
  endtask

  task automatic test_reset_mid_change();
    chg_rdy = 1'b0;
    eu2 = 1'b1; tick();
    eu2 = 1'b1; tick();
    cancel = 1'b1; tick();
    total_cnt++; if ({eu2o, busy, credit} !== {2'b11, 3'd4})
      $display("FAIL rm_pre got eu2o=%b busy=%b credit=%0d exp 1 1 4", eu2o, busy, credit);
    else pass_cnt++;
    rst = 1'b1; tick(); rst = 1'b0;
    total_cnt++; if ({eu2o, eu1o, busy, credit} !== {3'b000, 3'd0})
      $display("FAIL rm_post got eu2o=%b eu1o=%b busy=%b credit=%0d exp 0 0 0 0", eu2o, eu1o, busy, credit);
    else pass_cnt++;
    eu1 = 1'b1; tick();
    total_cnt++; if ({coin_rej, credit} !== {1'b0, 3'd1})
      $display("FAIL rm_collect got coin_rej=%b credit=%0d exp 0 1", coin_rej, credit);
    else pass_cnt++;
    rst = 1'b1; tick(); rst = 1'b0;
    $display("reset_mid_change: credit=%0d busy=%0d", credit, busy);
  endtask

`ifdef GWA_SALES_CNT_EN
  task automatic test_sales_cnt();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eu2 = 1'b1; tick();
      sel_a = 1'b1; tick();
      tick();
    end
    total_cnt++; if (sales_cnt !== 16'd3) $display("FAIL sales_cnt got %0d exp 3", sales_cnt); else pass_cnt++;
    $display("sales_cnt: %0d", sales_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_vend_b();
    test_overflow_change();
    test_no_fund_cancel();
    test_both_sel();
    test_sel_with_coin();
    test_reset_mid_change();
`ifdef GWA_SALES_CNT_EN
    test_sales_cnt();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
